spi_flash_reader: RTL and testbench
===================================

# spi_flash_reader

SPI-mode-0 initiator that issues single-lane READ (0x03) transactions to an external serial flash and streams the returned bytes out over a valid/ready interface. Sits inside the user project area behind the wrapper and drives a flash wired to user GPIOs. It is the initiator-side counterpart to the flash responder model used in the caravel-level testbenches, and is verified against that model. One clock domain, no buffering beyond a single output byte register.

## Interface

Parameters:
- CLK_DIV, 2, SCK half-period in wb_clk_i cycles; legal range 1..255.

Ports:
- wb_clk_i  input  1  system clock.
- wb_rst_i  input  1  reset, asynchronous, active-high.
- start  input  1  one-cycle request; accepted only in IDLE with len != 0.
- addr  input  24  flash byte address, sampled on accept.
- len  input  16  byte count, sampled on accept; 0 means ignore start.
- busy  output  1  high from the cycle after accept until the cycle done pulses.
- done  output  1  one-cycle pulse on return to IDLE.
- data_o  output  8  received byte, MSB first on the wire.
- data_valid  output  1  data_o holds an unconsumed byte.
- data_ready  input  1  consumer accepts data_o when data_valid && data_ready.
- flash_csb  output  1  chip select, active low.
- flash_clk  output  1  SCK, idles low.
- flash_io0  output  1  MOSI.
- flash_io1  input  1  MISO.

## Operation

- States: IDLE, SHIFT (command and address, 32 bits), DATA (8 bits per byte), HOLD, GAP.
- IDLE → SHIFT on accept: latch {8'h03, addr} into a 32-bit shift register; latch len into a byte counter; csb falls and io0 = bit 31 on the next edge.
- Bit cell: SCK low for CLK_DIV cycles with io0 stable, then SCK high for CLK_DIV cycles. io0 changes only on the edge on which SCK falls, or on the first edge of the transaction.
- io1 is captured on the wb_clk_i edge that drives SCK high.
- SHIFT: 32 bit cells, MSB first. After the 32nd falling edge, go to DATA. io0 = 0 from this point on.
- DATA: 8 bit cells shift io1 into rx[7:0]. On the 8th rising-edge sample, load data_o with {rx[6:0], io1} and set data_valid in the same cycle.
- Clear data_valid on the edge after a cycle with data_valid && data_ready.
- At the falling edge that ends a byte:
  - more bytes remain and data_valid is high → HOLD, with SCK low and csb low; exit HOLD the cycle after the handshake and start the next bit cell.
  - more bytes remain and data_valid is low → next byte immediately.
  - last byte → GAP.
- Byte counter decrements on each completed byte and is 16-bit unsigned with no wrap: len = 65535 produces exactly 65535 bytes.
- Address is sent verbatim; address wrap inside the flash is the flash's responsibility.
- GAP: csb high and SCK low. Stay in GAP for at least 2*CLK_DIV cycles and until data_valid is low. Then go to IDLE with done = 1 for one cycle and busy = 0 in that cycle.
- start while busy: ignored, with no queuing. start with len = 0: ignored, no done pulse.
- Reset values: flash_csb = 1, flash_clk = 0, flash_io0 = 0, busy = 0, done = 0, data_valid = 0, data_o = 0, state = IDLE. Reset asserted mid-transaction aborts it asynchronously and csb rises immediately.

## Timing

- Accept edge N: busy = 1, csb = 0, SCK = 0, io0 = 0 (bit 31 of 0x03) at edge N+1. First SCK rise at edge N+1+CLK_DIV.
- Bit cell is 2*CLK_DIV cycles. A transaction with no stalls has csb low for (32 + 8*len) * 2*CLK_DIV cycles.
- data_valid rises on the same edge as the 8th SCK rise of each byte. The minimum byte-to-byte spacing is 16*CLK_DIV cycles.
- done follows csb rising by max(2*CLK_DIV, cycles until the last byte is consumed) cycles.
- No SCK edges occur while in HOLD or GAP.

## Test plan

- Reset: assert wb_rst_i mid-idle → all outputs at their reset values; flash_clk shows no toggles.
- Basic read: CLK_DIV = 2, data_ready = 1, addr = 0x000010, len = 4, flash model preloaded with 0x11, 0x22, 0x33, 0x44 → MOSI carries 0x03 00 00 10; 64 SCK rising edges; csb low for exactly 256 cycles; data_o sequence 11, 22, 33, 44; one done pulse.
- Backpressure: as basic read, with data_ready held low for 50 cycles after the first byte → HOLD with SCK low and csb low, no extra SCK edges, byte sequence unchanged, csb low time extended by the stall.
- Ignored requests: start pulsed while busy, and start with len = 0 in IDLE → no new transaction, no extra done, in-flight data correct.
- Abort: wb_rst_i asserted after 10 SCK cycles → csb = 1 immediately, busy = 0. A following read of addr = 0x000000, len = 1 returns the correct byte.
- Fast divider: CLK_DIV = 1, len = 3 → SCK period is 2 cycles, csb low for 112 cycles, 3 correct bytes.

Source files
------------

// File: rtl/spi_flash_reader.sv
// spi_flash_reader: SPI mode-0 initiator issuing single-lane READ (0x03)
// transactions to a serial flash and streaming the returned bytes out over
// a valid/ready handshake with a single output byte register.
//
// Ports:
//   wb_clk_i, wb_rst_i     system clock, async active-high reset
//   start, addr, len       request; accepted in IDLE when len != 0
//   busy, done             transaction in flight / one-cycle completion pulse
//   data_o, data_valid,    received byte stream
//   data_ready
//   flash_csb, flash_clk,  flash pins (csb active low, SCK idles low,
//   flash_io0, flash_io1   io0 = MOSI, io1 = MISO)
//
// state | meaning
// IDLE  | waiting for start with len != 0
// SHIFT | clocking out 0x03 + 24-bit address, 32 bit cells
// DATA  | clocking in data bytes, 8 bit cells per byte
// HOLD  | byte complete, output register still full; SCK parked low
// GAP   | csb high, minimum deselect time and drain of last byte
module spi_flash_reader #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        start,
  input  logic [23:0] addr,
  input  logic [15:0] len,
  output logic        busy,
  output logic        done,
  output logic [7:0]  data_o,
  output logic        data_valid,
  input  logic        data_ready,
  output logic        flash_csb,
  output logic        flash_clk,
  output logic        flash_io0,
  input  logic        flash_io1
);

  typedef enum logic [2:0] {IDLE, SHIFT, DATA, HOLD, GAP} state_t;

  localparam logic [7:0] DIV_LOAD = 8'(CLK_DIV - 1);
  localparam logic [8:0] GAP_LOAD = 9'(2 * CLK_DIV - 1);

  state_t      state_q, state_d;
  logic [30:0] sr_q;
  logic [15:0] bytes_q;
  logic [4:0]  bit_q;
  logic [7:0]  div_q;
  logic [8:0]  gap_q;
  logic [6:0]  rx_q;
  logic        sck_q, csb_q, io0_q, done_q, valid_q;
  logic [7:0]  data_q;
  logic        accept, rise, fall, tc;

  assign tc = (div_q == 8'd0);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    rise    = 1'b0;
    fall    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && len != 16'd0) begin
          state_d = SHIFT;
          accept  = 1'b1;
        end
      end
      SHIFT, DATA: begin
        rise = tc && !sck_q;
        fall = tc && sck_q;
        if (fall && bit_q == 5'd0) begin
          if (state_q == SHIFT)                state_d = DATA;
          else if (bytes_q == 16'd1)           state_d = GAP;
          // a byte consumed in this very cycle does not need to stall
          else if (valid_q && !data_ready)     state_d = HOLD;
        end
      end
      HOLD: if (valid_q && data_ready) state_d = DATA;
      GAP:  if (gap_q == 9'd0 && !valid_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      sr_q    <= '0;
      bytes_q <= '0;
      bit_q   <= '0;
      div_q   <= '0;
      gap_q   <= '0;
      rx_q    <= '0;
      sck_q   <= 1'b0;
      csb_q   <= 1'b1;
      io0_q   <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      done_q <= (state_q == GAP) && (state_d == IDLE);
      if (valid_q && data_ready) valid_q <= 1'b0;

      if (accept) begin
        // bit 31 of the command (0x03) is 0 and goes out on this edge;
        // sr holds the remaining 31 bits
        sr_q    <= {7'h03, addr};
        io0_q   <= 1'b0;
        csb_q   <= 1'b0;
        sck_q   <= 1'b0;
        div_q   <= DIV_LOAD;
        bit_q   <= 5'd31;
        bytes_q <= len;
      end

      if (state_q == SHIFT || state_q == DATA) begin
        div_q <= tc ? DIV_LOAD : div_q - 8'd1;
        if (rise) begin
          sck_q <= 1'b1;
          if (state_q == DATA) begin
            rx_q <= {rx_q[5:0], flash_io1};
            if (bit_q == 5'd0) begin
              data_q  <= {rx_q, flash_io1};
              valid_q <= 1'b1;
            end
          end
        end
        if (fall) begin
          sck_q <= 1'b0;
          sr_q  <= {sr_q[29:0], 1'b0};
          if (bit_q == 5'd0) begin
            bit_q <= 5'd7;
            io0_q <= 1'b0;
            if (state_q == DATA) begin
              bytes_q <= bytes_q - 16'd1;
              if (state_d == GAP) begin
                csb_q <= 1'b1;
                gap_q <= GAP_LOAD;
              end
            end
          end else begin
            bit_q <= bit_q - 5'd1;
            if (state_q == SHIFT) io0_q <= sr_q[30];
          end
        end
      end

      if (state_q == GAP && gap_q != 9'd0) gap_q <= gap_q - 9'd1;
    end
  end

  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign data_o     = data_q;
  assign data_valid = valid_q;
  assign flash_csb  = csb_q;
  assign flash_clk  = sck_q;
  assign flash_io0  = io0_q;

endmodule

// File: tb/tb_spi_flash_reader.sv
module tb_spi_flash_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start1 = 1'b0, start2 = 1'b0;
  logic [23:0] addr = '0;
  logic [15:0] len = '0;
  logic        ready = 1'b1;
  logic        sel = 1'b0;
  logic        io1 = 1'b0;

  logic       busy1, done1, valid1, csb1, sck1, mosi1;
  logic       busy2, done2, valid2, csb2, sck2, mosi2;
  logic [7:0] data1, data2;

  always #5 clk = ~clk;

  spi_flash_reader #(.CLK_DIV(2)) dut1 (
    .wb_clk_i(clk), .wb_rst_i(rst), .start(start1), .addr(addr), .len(len),
    .busy(busy1), .done(done1), .data_o(data1), .data_valid(valid1),
    .data_ready(ready), .flash_csb(csb1), .flash_clk(sck1),
    .flash_io0(mosi1), .flash_io1(io1));

  spi_flash_reader #(.CLK_DIV(1)) dut2 (
    .wb_clk_i(clk), .wb_rst_i(rst), .start(start2), .addr(addr), .len(len),
    .busy(busy2), .done(done2), .data_o(data2), .data_valid(valid2),
    .data_ready(ready), .flash_csb(csb2), .flash_clk(sck2),
    .flash_io0(mosi2), .flash_io1(io1));

  wire       m_csb   = sel ? csb2   : csb1;
  wire       m_sck   = sel ? sck2   : sck1;
  wire       m_io0   = sel ? mosi2  : mosi1;
  wire       m_busy  = sel ? busy2  : busy1;
  wire       m_done  = sel ? done2  : done1;
  wire       m_valid = sel ? valid2 : valid1;
  wire [7:0] m_data  = sel ? data2  : data1;

  // flash responder: mode 0, drives MISO on SCK fall
  logic [7:0]  mem [0:63];
  logic [31:0] cmd = '0;
  int          fcnt = 0;
  int          idx;
  logic [5:0]  maddr;
  logic [7:0]  mbyte;

  always @(negedge m_csb or posedge m_sck) begin
    if (m_sck) begin
      if (fcnt < 32) cmd = {cmd[30:0], m_io0};
      fcnt = fcnt + 1;
    end else begin
      fcnt = 0;
    end
  end

  always @(negedge m_sck) begin
    if (!m_csb && fcnt >= 32) begin
      idx   = fcnt - 32;
      maddr = cmd[5:0] + 6'(idx / 8);
      mbyte = mem[maddr];
      io1   = mbyte[3'(7 - (idx % 8))];
    end
  end

  // monitor
  logic       mon_clr = 1'b0;
  int         cyc = 0, csb_low = 0, rises = 0, dones = 0;
  int         csb_rise_t = 0, done_t = 0;
  logic       sck_prev = 1'b0, csb_prev = 1'b1;
  logic [7:0] rxq [$];

  always @(negedge clk) begin
    if (mon_clr) begin
      cyc = 0; csb_low = 0; rises = 0; dones = 0;
      csb_rise_t = 0; done_t = 0;
      rxq.delete();
    end else begin
      cyc = cyc + 1;
      if (!m_csb) csb_low = csb_low + 1;
      if (m_sck && !sck_prev) rises = rises + 1;
      if (m_csb && !csb_prev) csb_rise_t = cyc;
      if (m_done) begin
        dones  = dones + 1;
        done_t = cyc;
      end
      if (m_valid && ready) rxq.push_back(m_data);
    end
    sck_prev = m_sck;
    csb_prev = m_csb;
  end

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    @(posedge clk); #1 mon_clr = 1'b1;
    @(negedge clk); #1 mon_clr = 1'b0;
  endtask

  task automatic kick(input logic [23:0] a, input logic [15:0] l);
    @(posedge clk); #1;
    addr = a; len = l;
    if (sel) start2 = 1'b1; else start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0; start2 = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && dones == 0; i++) @(negedge clk);
    chk("done_seen", dones, 1);
    repeat (6) @(negedge clk);
  endtask

  task automatic chk_bytes(input string tag, input int n, input logic [31:0] exp_word);
    logic [31:0] w;
    w = exp_word;
    chk({tag, "_nbytes"}, rxq.size(), n);
    for (int i = 0; i < n; i++) begin
      if (rxq.size() > 0) chk({tag, "_byte"}, rxq.pop_front(), {24'd0, w[31 - 8*i -: 8]});
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    mem[0]  = 8'hA5;
    mem[16] = 8'h11; mem[17] = 8'h22; mem[18] = 8'h33; mem[19] = 8'h44;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_csb", csb1, 1); chk("rst_clk", sck1, 0); chk("rst_io0", mosi1, 0);
    chk("rst_busy", busy1, 0); chk("rst_done", done1, 0);
    chk("rst_valid", valid1, 0); chk("rst_data", data1, 0);
    rst = 1'b0;
    clear_mon();
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1 chk("rst_mid_csb", csb1, 1); chk("rst_mid_busy", busy1, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_no_sck", rises, 0);

    // basic read
    sel = 1'b0; ready = 1'b1;
    clear_mon();
    kick(24'h000010, 16'd4);
    chk("basic_busy", busy1, 1); chk("basic_csb", csb1, 0);
    chk("basic_sck", sck1, 0); chk("basic_io0", mosi1, 0);
    wait_done(2000);
    chk("basic_cmd", cmd, 32'h03000010);
    chk("basic_rises", rises, 64);
    chk("basic_csb_low", csb_low, 256);
    chk("basic_gap", done_t - csb_rise_t, 4);
    chk("basic_busy_end", busy1, 0);
    chk_bytes("basic", 4, 32'h11223344);

    // backpressure: 50-cycle stall after the first byte
    ready = 1'b0;
    clear_mon();
    kick(24'h000010, 16'd4);
    for (int i = 0; i < 1000 && !m_valid; i++) @(negedge clk);
    chk("bp_valid", m_valid, 1);
    repeat (25) @(posedge clk);
    #2;
    chk("bp_hold_sck", m_sck, 0); chk("bp_hold_csb", m_csb, 0);
    chk("bp_hold_rises", rises, 40); chk("bp_hold_data", m_data, 8'h11);
    repeat (25) @(posedge clk);
    #1 ready = 1'b1;
    wait_done(2000);
    chk("bp_rises", rises, 64);
    chk("bp_csb_low", csb_low, 305);
    chk_bytes("bp", 4, 32'h11223344);

    // start while busy is ignored
    clear_mon();
    kick(24'h000010, 16'd4);
    repeat (20) @(posedge clk);
    #1 addr = 24'h000000; len = 16'd1; start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    wait_done(2000);
    repeat (40) @(negedge clk);
    chk("ign_cmd", cmd, 32'h03000010);
    chk("ign_dones", dones, 1);
    chk("ign_rises", rises, 64);
    chk_bytes("ign", 4, 32'h11223344);

    // start with len = 0 is ignored
    clear_mon();
    kick(24'h000010, 16'd0);
    repeat (40) @(negedge clk);
    chk("len0_dones", dones, 0); chk("len0_csb_low", csb_low, 0);
    chk("len0_busy", busy1, 0);

    // abort mid-transaction
    clear_mon();
    kick(24'h000010, 16'd4);
    for (int i = 0; i < 1000 && rises < 10; i++) @(negedge clk);
    chk("abort_rises", rises, 10);
    #2 rst = 1'b1;
    #1;
    chk("abort_csb", csb1, 1); chk("abort_busy", busy1, 0);
    chk("abort_sck", sck1, 0); chk("abort_io0", mosi1, 0);
    @(posedge clk); #1 rst = 1'b0;
    clear_mon();
    kick(24'h000000, 16'd1);
    wait_done(2000);
    chk("after_cmd", cmd, 32'h03000000);
    chk("after_csb_low", csb_low, 160);
    chk_bytes("after", 1, 32'hA5000000);

    // fast divider
    sel = 1'b1;
    clear_mon();
    kick(24'h000010, 16'd3);
    chk("fast_busy", busy2, 1); chk("fast_csb", csb2, 0);
    wait_done(2000);
    chk("fast_cmd", cmd, 32'h03000010);
    chk("fast_rises", rises, 56);
    chk("fast_csb_low", csb_low, 112);
    chk("fast_gap", done_t - csb_rise_t, 2);
    chk_bytes("fast", 3, 32'h11223300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
